// File: rtl/lia_lpf_decimator_if.sv
// ============================================================================
// lia_lpf_decimator_if : mixer I/Q input stream and averaged I/Q output stream
// Rev 1.0
// ============================================================================
`default_nettype none

interface lia_lpf_decimator_if #(
   parameter int IN_W = 24
);
   logic signed [IN_W-1:0] mixer_i_in;
   logic signed [IN_W-1:0] mixer_q_in;
   logic                   mixer_valid;
   logic signed [IN_W-1:0] lpf_i_out;
   logic signed [IN_W-1:0] lpf_q_out;
   logic                   lpf_valid;

   modport master (
      output mixer_i_in, mixer_q_in, mixer_valid,
      input  lpf_i_out, lpf_q_out, lpf_valid
   );

   modport slave (
      input  mixer_i_in, mixer_q_in, mixer_valid,
      output lpf_i_out, lpf_q_out, lpf_valid
   );
endinterface

`default_nettype wire

// File: rtl/lia_lpf_decimator.sv
// ============================================================================
// lia_lpf_decimator : boxcar low-pass + 2^N decimator for lock-in I/Q samples
// Optional magnitude output enabled by macro LIA_LPF_MAG_EN.   Rev 1.0
// ============================================================================
`default_nettype none

module lia_lpf_decimator #(
   parameter int IN_W     = 24,
   parameter int MAX_LOG2 = 12
) (
   input  wire logic            clk,
   input  wire logic            rst_n,
   lia_lpf_decimator_if.slave   bus,
   input  wire logic [3:0]      decim_log2,
   input  wire logic            clear,
   output logic                 cfg_clamped
`ifdef LIA_LPF_MAG_EN
   ,
   output logic [IN_W:0]        lpf_mag_out,
   output logic                 lpf_mag_valid
`endif
);

   localparam int         ACC_W    = IN_W + MAX_LOG2;
   localparam int         CNT_W    = MAX_LOG2 + 1;
   localparam logic [3:0] C_MAX_NE = 4'(MAX_LOG2);

   typedef enum logic [1:0] {
      S_LOAD  = 2'd0,
      S_ACCUM = 2'd1,
      S_DUMP  = 2'd2
   } state_t;

   state_t                  r_state;
   logic [3:0]              r_ne;
   logic [3:0]              r_decim;
   logic [CNT_W-1:0]        r_cnt;
   logic signed [ACC_W-1:0] r_acc_i;
   logic signed [ACC_W-1:0] r_acc_q;
   logic signed [IN_W-1:0]  r_lpf_i;
   logic signed [IN_W-1:0]  r_lpf_q;
   logic                    r_lpf_valid;

   logic                    w_clamped;
   logic [3:0]              w_ne;
   logic                    w_cfg_change;
   logic                    w_last;
   logic signed [ACC_W-1:0] w_in_i;
   logic signed [ACC_W-1:0] w_in_q;

   assign w_clamped    = (32'(decim_log2) > MAX_LOG2);
   assign w_ne         = w_clamped ? C_MAX_NE : decim_log2;
   assign cfg_clamped  = w_clamped;
   // Any change of the raw exponent restarts the block, even if Ne is unchanged.
   assign w_cfg_change = (decim_log2 != r_decim);
   assign w_last       = ((r_cnt + CNT_W'(1)) == (CNT_W'(1) << r_ne));
   assign w_in_i       = ACC_W'(bus.mixer_i_in);
   assign w_in_q       = ACC_W'(bus.mixer_q_in);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_LOAD;
         r_ne        <= 4'd0;
         r_decim     <= 4'd0;
         r_cnt       <= '0;
         r_acc_i     <= '0;
         r_acc_q     <= '0;
         r_lpf_i     <= '0;
         r_lpf_q     <= '0;
         r_lpf_valid <= 1'b0;
      end else begin
         r_lpf_valid <= 1'b0;
         if (clear) begin
            r_state <= S_LOAD;
         end else begin
            case (r_state)
               S_LOAD: begin
                  r_ne    <= w_ne;
                  r_decim <= decim_log2;
                  r_cnt   <= '0;
                  r_acc_i <= '0;
                  r_acc_q <= '0;
                  r_state <= S_ACCUM;
               end
               S_ACCUM: begin
                  if (w_cfg_change) begin
                     r_state <= S_LOAD;
                  end else if (bus.mixer_valid) begin
                     r_acc_i <= r_acc_i + w_in_i;
                     r_acc_q <= r_acc_q + w_in_q;
                     r_cnt   <= r_cnt + CNT_W'(1);
                     if (w_last) begin
                        r_state <= S_DUMP;
                     end
                  end
               end
               S_DUMP: begin
                  if (w_cfg_change) begin
                     r_state <= S_LOAD;
                  end else begin
                     r_lpf_i     <= IN_W'(r_acc_i >>> r_ne);
                     r_lpf_q     <= IN_W'(r_acc_q >>> r_ne);
                     r_lpf_valid <= 1'b1;
                     if (bus.mixer_valid) begin
                        r_acc_i <= w_in_i;
                        r_acc_q <= w_in_q;
                        r_cnt   <= CNT_W'(1);
                        // At Ne=0 the reloaded sample is already a full block.
                        r_state <= (r_ne == 4'd0) ? S_DUMP : S_ACCUM;
                     end else begin
                        r_acc_i <= '0;
                        r_acc_q <= '0;
                        r_cnt   <= '0;
                        r_state <= S_ACCUM;
                     end
                  end
               end
               default: r_state <= S_LOAD;
            endcase
         end
      end
   end

   assign bus.lpf_i_out = r_lpf_i;
   assign bus.lpf_q_out = r_lpf_q;
   assign bus.lpf_valid = r_lpf_valid;

`ifdef LIA_LPF_MAG_EN
   localparam logic [IN_W:0] C_ONE = {{IN_W{1'b0}}, 1'b1};

   logic [IN_W:0] w_ext_i;
   logic [IN_W:0] w_ext_q;
   logic [IN_W:0] w_abs_i;
   logic [IN_W:0] w_abs_q;
   logic [IN_W:0] w_max;
   logic [IN_W:0] w_min;
   logic [IN_W:0] r_mag;
   logic          r_mag_valid;

   // One extra bit so |most-negative| is representable.
   assign w_ext_i = {r_lpf_i[IN_W-1], r_lpf_i};
   assign w_ext_q = {r_lpf_q[IN_W-1], r_lpf_q};
   assign w_abs_i = w_ext_i[IN_W] ? (~w_ext_i + C_ONE) : w_ext_i;
   assign w_abs_q = w_ext_q[IN_W] ? (~w_ext_q + C_ONE) : w_ext_q;
   assign w_max   = (w_abs_i >= w_abs_q) ? w_abs_i : w_abs_q;
   assign w_min   = (w_abs_i >= w_abs_q) ? w_abs_q : w_abs_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_mag       <= '0;
         r_mag_valid <= 1'b0;
      end else begin
         r_mag_valid <= r_lpf_valid;
         if (r_lpf_valid) begin
            r_mag <= w_max + (w_min >> 1);
         end
      end
   end

   assign lpf_mag_out   = r_mag;
   assign lpf_mag_valid = r_mag_valid;
`endif

endmodule

`default_nettype wire
